// File: rtl/adc_framer_pkg.sv
// adc_framer_pkg
// Shared definitions for the ADC framer: the capture state encoding, the
// acquisition mode codes as they appear on the mode input, and a helper that
// folds the reserved mode code onto FREE.
package adc_framer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   localparam logic [1:0] FREE   = 2'd0;
   localparam logic [1:0] SINGLE = 2'd1;
   localparam logic [1:0] TRIG   = 2'd2;

   // Mode code 3 is reserved and behaves exactly like free-running capture.
   function automatic logic [1:0] normMode(input logic [1:0] m);
      return (m == 2'd3) ? FREE : m;
   endfunction

endpackage

// File: rtl/adc_framer_if.sv
// adc_framer_if
// Buffer write port driven by the framer into the sample RAM.
//   dout : quantised sample to store
//   addr : {bank, slot} write address
//   we   : write strobe, one sample per asserted cycle
// Modports: master (framer side, drives), slave (buffer side, receives).
interface adc_framer_if #(
   parameter int OW = 8,
   parameter int AW = 11
);

   logic [OW-1:0] dout;
   logic [AW-1:0] addr;
   logic          we;

   modport master (output dout, addr, we);
   modport slave  (input  dout, addr, we);

endinterface

// File: rtl/adc_framer_quant.sv
// adc_quant
// Reduces a DW-bit ADC sample to OW bits by rounding half up on the first
// discarded bit, saturating to all ones when the rounding carries out.
//   din_i : raw ADC sample (DW bits)
//   q_o   : quantised sample (OW bits)
module adc_quant #(
   parameter int DW = 10,
   parameter int OW = 8
)(
   input  logic [DW-1:0] din_i,
   output logic [OW-1:0] q_o
);

   generate
      if (DW == OW) begin : gNoRound
         assign q_o = din_i;
      end else begin : gRound
         // One spare bit on top catches the carry out of the rounding add.
         logic [OW:0] sum;
         assign sum = {1'b0, din_i[DW-1:DW-OW]} + {{OW{1'b0}}, din_i[DW-OW-1]};
         assign q_o = sum[OW] ? {OW{1'b1}} : sum[OW-1:0];
      end
   endgenerate

endmodule

// File: rtl/adc_framer.sv
// adc_framer
// Quantises a continuous ADC stream and writes frames of 2^(AW-1) samples
// into alternating buffer banks, in free-running, single-shot or triggered
// mode, with optional decimation and per-frame over-range reporting.
//   clk50, reset          : clock and asynchronous active-high reset
//   din, ovr              : ADC sample and over-range flag, every cycle
//   mode, arm, dec        : acquisition mode, single-shot start, decimation
//   trig_lvl              : rising-edge trigger threshold (quantised units)
//   wr                    : buffer write port (dout/addr/we)
//   idx, frame_done       : completed bank number and its one-cycle pulse
//   ovr_flag, busy        : over-range seen in last frame; ARMED/CAPTURE
module adc_framer
   import adc_framer_pkg::*;
#(
   parameter int DW   = 10,
   parameter int OW   = 8,
   parameter int AW   = 11,
   parameter int DECW = 8
)(
   input  logic            clk50,
   input  logic            reset,
   input  logic [DW-1:0]   din,
   input  logic            ovr,
   input  logic [1:0]      mode,
   input  logic            arm,
   input  logic [DECW-1:0] dec,
   input  logic [OW-1:0]   trig_lvl,
   adc_framer_if.master    wr,
   output logic            idx,
   output logic            frame_done,
   output logic            ovr_flag,
   output logic            busy
);

   logic [OW-1:0]   qNew;
   logic [OW-1:0]   q_q, qPrev_q;
   logic            ovr_q;
   logic [OW-1:0]   dout_q;
   logic [AW-1:0]   addr_q;
   logic            we_q;
   state_t          state_q, state_d;
   logic [AW-2:0]   slot_q, slot_d;
   logic            bank_q, bank_d;
   logic [DECW-1:0] decCnt_q, decCnt_d, decLat_q, decLat_d;
   logic [1:0]      modeLat_q, modeLat_d;
   logic            acc_q, acc_d;
   logic            idx_q, idx_d;
   logic            frameDone_q, frameDone_d;
   logic            ovrFlag_q, ovrFlag_d;
   logic            wrEn;
   logic            crossing;
   logic [1:0]      liveMode;

   adc_quant #(.DW(DW), .OW(OW)) uQuant (
      .din_i (din),
      .q_o   (qNew)
   );

   assign liveMode = normMode(mode);
   assign crossing = (qPrev_q < trig_lvl) && (q_q >= trig_lvl);

   // Stage 1 holds the current and previous quantised sample for the
   // trigger comparator; stage 2 is the registered buffer write port, whose
   // data and address only move when a sample is actually stored.
   always_ff @(posedge clk50 or posedge reset) begin
      if (reset) begin
         q_q     <= '0;
         qPrev_q <= '0;
         ovr_q   <= 1'b0;
         dout_q  <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
      end else begin
         q_q     <= qNew;
         qPrev_q <= q_q;
         ovr_q   <= ovr;
         we_q    <= wrEn;
         if (wrEn) begin
            dout_q <= q_q;
            addr_q <= {bank_q, slot_q};
         end
      end
   end

   // Capture state, frame position and per-frame bookkeeping.
   always_ff @(posedge clk50 or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         slot_q      <= '0;
         bank_q      <= 1'b0;
         decCnt_q    <= '0;
         decLat_q    <= '0;
         modeLat_q   <= FREE;
         acc_q       <= 1'b0;
         idx_q       <= 1'b0;
         frameDone_q <= 1'b0;
         ovrFlag_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         bank_q      <= bank_d;
         decCnt_q    <= decCnt_d;
         decLat_q    <= decLat_d;
         modeLat_q   <= modeLat_d;
         acc_q       <= acc_d;
         idx_q       <= idx_d;
         frameDone_q <= frameDone_d;
         ovrFlag_q   <= ovrFlag_d;
      end
   end

   // Next-state logic. A frame's first cycle always stores its sample: entry
   // from IDLE leaves the decimation counter at zero, and a trigger crossing
   // stores the crossing sample directly and then loads dec. mode and dec are
   // latched only when a frame begins.
   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      bank_d      = bank_q;
      decCnt_d    = decCnt_q;
      decLat_d    = decLat_q;
      modeLat_d   = modeLat_q;
      acc_d       = acc_q | ovr_q;
      idx_d       = idx_q;
      frameDone_d = 1'b0;
      ovrFlag_d   = ovrFlag_q;
      wrEn        = 1'b0;

      case (state_q)
         IDLE: begin
            acc_d    = 1'b0;
            decCnt_d = '0;
            if (liveMode == TRIG) begin
               state_d = ARMED;
            end else if (liveMode == FREE || arm) begin
               state_d   = CAPTURE;
               modeLat_d = liveMode;
               decLat_d  = dec;
            end
         end
         ARMED: begin
            acc_d = 1'b0;
            if (crossing) begin
               wrEn      = 1'b1;
               acc_d     = ovr_q;
               modeLat_d = TRIG;
               decLat_d  = dec;
               decCnt_d  = dec;
               state_d   = CAPTURE;
            end
         end
         CAPTURE: begin
            if (decCnt_q == '0) begin
               wrEn     = 1'b1;
               decCnt_d = decLat_q;
            end else begin
               decCnt_d = decCnt_q - DECW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // The slot counter wraps to zero on its own after the last slot.
      if (wrEn) begin
         slot_d = slot_q + (AW-1)'(1);
         if (slot_q == '1) begin
            frameDone_d = 1'b1;
            idx_d       = bank_q;
            bank_d      = ~bank_q;
            ovrFlag_d   = acc_d;
            acc_d       = 1'b0;
            case (modeLat_d)
               SINGLE:  state_d = IDLE;
               TRIG:    state_d = ARMED;
               default: begin
                  // Free-running continues straight into the next frame
                  // unless the mode input has since moved away from FREE.
                  if (liveMode == FREE) begin
                     state_d  = CAPTURE;
                     decLat_d = dec;
                     decCnt_d = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end
            endcase
         end
      end
   end

   assign wr.dout    = dout_q;
   assign wr.addr    = addr_q;
   assign wr.we      = we_q;
   assign idx        = idx_q;
   assign frame_done = frameDone_q;
   assign ovr_flag   = ovrFlag_q;
   assign busy       = (state_q != IDLE);

endmodule
